// File: rtl/nonogram_pkg.sv
// nonogram_pkg: frame header constants and state types shared by the solution frame transmitter
package nonogram_pkg;
  localparam logic [7:0] HDR_M    = 8'hE0;
  localparam logic [7:0] HDR_N    = 8'hE1;
  localparam logic [7:0] HDR_ROW  = 8'h80;
  localparam logic [7:0] HDR_CSUM = 8'hC0;
  localparam logic [7:0] STOP     = 8'h00;
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_TX, FINISH} tx_state_t;
  typedef enum logic [3:0] {S_HM, S_M, S_HN, S_N, S_RH, S_RD, S_CH, S_CV, S_P0, S_P1} seq_t;
endpackage

// File: rtl/solution_frame_tx_row_byte_sel.sv
// row_byte_sel: picks data byte k of row r from the grid, zeroing columns at or beyond n
module row_byte_sel #(
  parameter int MAX_DIM = 11,
  parameter int DIM_W   = 4,
  parameter int KW      = 2
) (
  input  logic [MAX_DIM*MAX_DIM-1:0] i_grid,
  input  logic [DIM_W-1:0]           i_row,
  input  logic [KW-1:0]              i_k,
  input  logic [DIM_W-1:0]           i_n,
  output logic [7:0]                 o_byte
);
  logic [31:0] w_off;
  logic [7:0]  w_win, w_mask;
  assign w_off = 32'(i_row) * MAX_DIM + 32'(i_k) * 32'd8;
  assign w_win = 8'({8'h00, i_grid} >> w_off);
  for (genvar i = 0; i < 8; i++) begin : g_mask
    assign w_mask[i] = (32'(i_k) * 32'd8 + 32'(i)) < 32'(i_n);
  end
  assign o_byte = w_win & w_mask;
endmodule

// File: rtl/solution_frame_tx.sv
// solution_frame_tx: serialises a solved m x n nonogram grid into a byte-framed UART message
// Ports: clk, rst (sync, active high); valid_in/solution/m/n grid input; transmit_done UART ack;
//        send/byte_out byte handoff; busy frame active; done final ack pulse; err bad-dimension pulse.
// Define SOLUTION_FRAME_CHECKSUM_EN to append the C0,<xor> checksum pair before the stop bytes.
module solution_frame_tx
  import nonogram_pkg::*;
#(
  parameter int MAX_DIM = 11,
  parameter int DIM_W   = $clog2(MAX_DIM + 1),
  parameter int ROW_B   = (MAX_DIM + 7) / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [MAX_DIM*MAX_DIM-1:0] solution,
  input  logic [DIM_W-1:0]           m,
  input  logic [DIM_W-1:0]           n,
  input  logic                       transmit_done,
  output logic                       send,
  output logic [7:0]                 byte_out,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int KW = $clog2(ROW_B + 1);
  localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_DIM);
`ifdef SOLUTION_FRAME_CHECKSUM_EN
  localparam seq_t SEQ_TAIL = S_CH;
`else
  localparam seq_t SEQ_TAIL = S_P0;
`endif
  if (MAX_DIM > 127) begin : g_dim_chk
    $error("MAX_DIM must not exceed 127: row index is encoded in 7 bits");
  end
  tx_state_t                  r_state;
  seq_t                       r_seq;
  logic [MAX_DIM*MAX_DIM-1:0] r_grid;
  logic [DIM_W-1:0]           r_m, r_n, r_row;
  logic [KW-1:0]              r_k;
  logic                       r_last, r_send, r_busy, r_done, r_err;
  logic [7:0]                 r_byte;
  logic [7:0]                 w_data, w_byte, w_csum;
  logic [KW-1:0]              w_last_k;
  logic                       w_ok, w_k_end;
  assign send     = r_send;
  assign byte_out = r_byte;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign w_ok     = (m != '0) && (n != '0) && (m <= DIM_MAX) && (n <= DIM_MAX);
  assign w_last_k = KW'((32'(r_n) + 32'd7) / 32'd8 - 32'd1);
  assign w_k_end  = r_k == w_last_k;
  row_byte_sel #(.MAX_DIM(MAX_DIM), .DIM_W(DIM_W), .KW(KW)) u_sel (
    .i_grid(r_grid),
    .i_row (r_row),
    .i_k   (r_k),
    .i_n   (r_n),
    .o_byte(w_data)
  );
  always_comb begin
    w_byte = (r_seq == S_HM) ? HDR_M :
             (r_seq == S_M)  ? 8'(r_m) :
             (r_seq == S_HN) ? HDR_N :
             (r_seq == S_N)  ? 8'(r_n) :
             (r_seq == S_RH) ? (HDR_ROW | {1'b0, 7'(r_row)}) :
             (r_seq == S_RD) ? w_data :
             (r_seq == S_CH) ? HDR_CSUM :
             (r_seq == S_CV) ? w_csum : STOP;
  end
`ifdef SOLUTION_FRAME_CHECKSUM_EN
  logic [7:0] r_csum;
  // Only bytes from the first header through the last row data byte are folded in.
  always_ff @(posedge clk) begin
    if (rst || r_state == IDLE) r_csum <= '0;
    else if (r_state == LOAD && r_seq < S_CH) r_csum <= r_csum ^ w_byte;
  end
  assign w_csum = r_csum;
`else
  assign w_csum = STOP;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_seq   <= S_HM;
      r_grid  <= '0;
      r_m     <= '0;
      r_n     <= '0;
      r_row   <= '0;
      r_k     <= '0;
      r_last  <= 1'b0;
      r_send  <= 1'b0;
      r_byte  <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_send <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: if (valid_in) begin
          if (w_ok) begin
            r_grid  <= solution;
            r_m     <= m;
            r_n     <= n;
            r_row   <= '0;
            r_k     <= '0;
            r_seq   <= S_HM;
            r_last  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end else r_err <= 1'b1;
        end
        LOAD: begin
          r_byte  <= w_byte;
          r_send  <= 1'b1;
          r_last  <= r_seq == S_P1;
          r_state <= SEND;
          case (r_seq)
            S_HM: r_seq <= S_M;
            S_M:  r_seq <= S_HN;
            S_HN: r_seq <= S_N;
            S_N:  r_seq <= S_RH;
            S_RH: begin
              r_k   <= '0;
              r_seq <= S_RD;
            end
            S_RD: begin
              r_k   <= w_k_end ? '0 : r_k + 1'b1;
              r_row <= w_k_end ? r_row + 1'b1 : r_row;
              r_seq <= !w_k_end ? S_RD : (r_row == r_m - 1'b1) ? SEQ_TAIL : S_RH;
            end
            S_CH: r_seq <= S_CV;
            S_CV: r_seq <= S_P0;
            S_P0: r_seq <= S_P1;
            default: r_seq <= r_seq;
          endcase
        end
        SEND: r_state <= WAIT_TX;
        WAIT_TX: if (transmit_done) begin
          r_state <= r_last ? FINISH : LOAD;
          r_done  <= r_last;
          r_busy  <= !r_last;
        end
        FINISH: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_solution_frame_tx.sv
// tb_solution_frame_tx: directed self-checking bench for solution_frame_tx with a UART TX responder
module tb_solution_frame_tx;
  localparam int MD = 11;
  localparam int GW = MD * MD;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, uart_done = 1'b0, extra_done = 1'b0, hold = 1'b0;
  logic transmit_done;
  logic [GW-1:0] solution = '0;
  logic [3:0] dm = '0, dn = '0;
  logic send, busy, done, err;
  logic [7:0] byte_out;
  int nvec = 0, nbad = 0, cyc = 0, pend = 0, sends = 0, dones = 0, errs = 0, busy_hi = 0;
  int done_cyc = -1, err_cyc = -1, v_cyc = 0;
  bq_t cap;
  int send_cyc[$], ack_cyc[$];
  logic [GW-1:0] g1, ga;
  assign transmit_done = uart_done | extra_done;
  solution_frame_tx dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .solution(solution), .m(dm), .n(dn),
    .transmit_done(transmit_done), .send(send), .byte_out(byte_out), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  function automatic bq_t frame_of(input logic [GW-1:0] g, input int rows, input int cols);
    bq_t q;
    logic [7:0] b, x;
    q.push_back(8'hE0); q.push_back(8'(rows)); q.push_back(8'hE1); q.push_back(8'(cols));
    for (int r = 0; r < rows; r++) begin
      q.push_back(8'h80 | 8'(r));
      for (int k = 0; k < (cols + 7) / 8; k++) begin
        b = '0;
        for (int i = 0; i < 8; i++)
          if (8 * k + i < cols && g[7'(r * MD + 8 * k + i)]) b = b | (8'h01 << i);
        q.push_back(b);
      end
    end
`ifdef SOLUTION_FRAME_CHECKSUM_EN
    x = '0;
    foreach (q[i]) x = x ^ q[i];
    q.push_back(8'hC0); q.push_back(x);
`endif
    q.push_back(8'h00); q.push_back(8'h00);
    return q;
  endfunction
  // Monitor plus UART model: outputs are read at the falling edge, then transmit_done is driven
  // for the current cycle, three cycles after each observed send.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (send === 1'b1) begin cap.push_back(byte_out); send_cyc.push_back(cyc); sends++; end
    if (done === 1'b1) begin dones++; done_cyc = cyc; end
    if (err === 1'b1) begin errs++; err_cyc = cyc; end
    if (busy === 1'b1) busy_hi++;
    uart_done = 1'b0;
    if (pend > 0) begin
      if (!(pend == 1 && hold)) pend--;
      if (pend == 0) begin uart_done = 1'b1; ack_cyc.push_back(cyc); end
    end
    if (send === 1'b1) pend = 3;
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic pulse_valid(input logic [GW-1:0] g, input int rows, input int cols);
    tick();
    solution = g; dm = 4'(rows); dn = 4'(cols); valid_in = 1'b1; v_cyc = cyc;
    tick();
    valid_in = 1'b0;
  endtask
  task automatic test_reset();
    repeat (3) tick();
    nvec++; if (send !== 1'b0) begin nbad++; $display("FAIL reset_send got %b want 0", send); end
    nvec++; if (byte_out !== 8'h00) begin nbad++; $display("FAIL reset_byte got %h want 00", byte_out); end
    nvec++; if (busy !== 1'b0) begin nbad++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nbad++; $display("FAIL reset_done got %b want 0", done); end
    nvec++; if (err !== 1'b0) begin nbad++; $display("FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_small();
    bq_t exp;
    int d0;
    exp = {8'hE0, 8'h03, 8'hE1, 8'h03, 8'h80, 8'h03, 8'h81, 8'h02, 8'h82, 8'h05};
`ifdef SOLUTION_FRAME_CHECKSUM_EN
    exp.push_back(8'hC0); exp.push_back(8'h86);
`endif
    exp.push_back(8'h00); exp.push_back(8'h00);
    cap.delete(); send_cyc.delete(); ack_cyc.delete(); d0 = dones;
    pulse_valid(g1, 3, 3);
    for (int i = 0; i < 400 && dones == d0; i++) tick();
    nvec++; if (dones != d0 + 1) begin nbad++; $display("FAIL small_done got %0d want %0d", dones - d0, 1); end
    nvec++; if (cap.size() != exp.size()) begin nbad++; $display("FAIL small_len got %0d want %0d", cap.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      nvec++;
      if (i >= cap.size() || cap[i] !== exp[i]) begin nbad++; $display("FAIL small_byte[%0d] got %h want %h", i, cap[i], exp[i]); end
    end
    nvec++; if (send_cyc.size() < 1 || send_cyc[0] != v_cyc + 2) begin nbad++; $display("FAIL small_first_send got %0d want %0d", send_cyc[0], v_cyc + 2); end
    nvec++; if (send_cyc.size() < 2 || ack_cyc.size() < 1 || send_cyc[1] != ack_cyc[0] + 2) begin nbad++; $display("FAIL small_ack_to_send got %0d want %0d", send_cyc[1], ack_cyc[0] + 2); end
    nvec++; if (ack_cyc.size() < 1 || done_cyc != ack_cyc[$] + 1) begin nbad++; $display("FAIL small_done_lat got %0d want %0d", done_cyc, ack_cyc[$] + 1); end
    nvec++; if (busy !== 1'b0) begin nbad++; $display("FAIL small_busy_end got %b want 0", busy); end
    tick();
    nvec++; if (done !== 1'b0) begin nbad++; $display("FAIL small_done_pulse got %b want 0", done); end
  endtask
  task automatic test_full();
    bq_t exp;
    int d0;
    exp = frame_of('1, 11, 11);
    cap.delete(); d0 = dones;
    pulse_valid('1, 11, 11);
    for (int i = 0; i < 1000 && dones == d0; i++) tick();
`ifdef SOLUTION_FRAME_CHECKSUM_EN
    nvec++; if (cap.size() != 41) begin nbad++; $display("FAIL full_len got %0d want 41", cap.size()); end
`else
    nvec++; if (cap.size() != 39) begin nbad++; $display("FAIL full_len got %0d want 39", cap.size()); end
`endif
    for (int i = 0; i < exp.size(); i++) begin
      nvec++;
      if (i >= cap.size() || cap[i] !== exp[i]) begin nbad++; $display("FAIL full_byte[%0d] got %h want %h", i, cap[i], exp[i]); end
    end
  endtask
  task automatic test_bad_dims();
    int tm[4] = '{0, 12, 3, 3};
    int tn[4] = '{3, 3, 0, 15};
    int e0, s0, b0;
    for (int t = 0; t < 4; t++) begin
      e0 = errs; s0 = sends; b0 = busy_hi;
      pulse_valid(g1, tm[t], tn[t]);
      repeat (6) tick();
      nvec++; if (errs != e0 + 1) begin nbad++; $display("FAIL bad_err_count[%0d] got %0d want 1", t, errs - e0); end
      nvec++; if (err_cyc != v_cyc + 1) begin nbad++; $display("FAIL bad_err_cycle[%0d] got %0d want %0d", t, err_cyc, v_cyc + 1); end
      nvec++; if (sends != s0) begin nbad++; $display("FAIL bad_send[%0d] got %0d want %0d", t, sends, s0); end
      nvec++; if (busy_hi != b0) begin nbad++; $display("FAIL bad_busy[%0d] got %0d want %0d", t, busy_hi, b0); end
    end
  endtask
  task automatic test_ignore();
    bq_t exp;
    int d0, s0, bad;
    logic prev, pulsed;
    exp = frame_of(ga, 5, 9);
    cap.delete(); send_cyc.delete(); ack_cyc.delete(); d0 = dones; s0 = sends;
    prev = 1'b0; pulsed = 1'b0; bad = 0;
    extra_done = 1'b1;
    tick();
    extra_done = 1'b0;
    pulse_valid(ga, 5, 9);
    for (int i = 0; i < 1500 && dones == d0; i++) begin
      tick();
      extra_done = send | prev;
      prev = uart_done;
      if (!pulsed && sends == s0 + 3) begin solution = ~ga; dm = 4'd2; dn = 4'd2; valid_in = 1'b1; pulsed = 1'b1; end
      else valid_in = 1'b0;
    end
    extra_done = 1'b0; valid_in = 1'b0;
    nvec++; if (cap.size() != exp.size()) begin nbad++; $display("FAIL ignore_len got %0d want %0d", cap.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      nvec++;
      if (i >= cap.size() || cap[i] !== exp[i]) begin nbad++; $display("FAIL ignore_byte[%0d] got %h want %h", i, cap[i], exp[i]); end
    end
    for (int i = 0; i + 1 < send_cyc.size(); i++)
      if (i >= ack_cyc.size() || send_cyc[i + 1] != ack_cyc[i] + 2) bad++;
    nvec++; if (bad != 0) begin nbad++; $display("FAIL ignore_spacing got %0d bad gaps want 0", bad); end
  endtask
  task automatic test_reset_mid();
    bq_t exp;
    int d0, s0;
    exp = frame_of(g1, 3, 3);
    s0 = sends;
    pulse_valid(g1, 3, 3);
    for (int i = 0; i < 200 && sends < s0 + 5; i++) tick();
    nvec++; if (sends != s0 + 5) begin nbad++; $display("FAIL rmid_reach got %0d sends want 5", sends - s0); end
    rst = 1'b1;
    pend = 0;
    tick();
    rst = 1'b0;
    nvec++; if (send !== 1'b0) begin nbad++; $display("FAIL rmid_send got %b want 0", send); end
    nvec++; if (byte_out !== 8'h00) begin nbad++; $display("FAIL rmid_byte got %h want 00", byte_out); end
    nvec++; if (busy !== 1'b0) begin nbad++; $display("FAIL rmid_busy got %b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nbad++; $display("FAIL rmid_done got %b want 0", done); end
    nvec++; if (err !== 1'b0) begin nbad++; $display("FAIL rmid_err got %b want 0", err); end
    repeat (4) tick();
    cap.delete(); d0 = dones;
    pulse_valid(g1, 3, 3);
    for (int i = 0; i < 400 && dones == d0; i++) tick();
    nvec++; if (cap.size() < 1 || cap[0] !== 8'hE0) begin nbad++; $display("FAIL rmid_first got %h want e0", cap[0]); end
    nvec++; if (cap.size() != exp.size()) begin nbad++; $display("FAIL rmid_len got %0d want %0d", cap.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      nvec++;
      if (i >= cap.size() || cap[i] !== exp[i]) begin nbad++; $display("FAIL rmid_byte[%0d] got %h want %h", i, cap[i], exp[i]); end
    end
  endtask
  task automatic test_stall();
    bq_t exp;
    int d0, s0, bad;
    logic [7:0] held;
    exp = frame_of(ga, 7, 6);
    cap.delete(); d0 = dones; s0 = sends; bad = 0;
    pulse_valid(ga, 7, 6);
    for (int i = 0; i < 200 && sends < s0 + 2; i++) tick();
    hold = 1'b1;
    held = byte_out;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (send !== 1'b0 || byte_out !== held || busy !== 1'b1) bad++;
    end
    nvec++; if (bad != 0) begin nbad++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
    nvec++; if (sends != s0 + 2) begin nbad++; $display("FAIL stall_sends got %0d want 2", sends - s0); end
    hold = 1'b0;
    for (int i = 0; i < 600 && dones == d0; i++) tick();
    nvec++; if (cap.size() != exp.size()) begin nbad++; $display("FAIL stall_len got %0d want %0d", cap.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      nvec++;
      if (i >= cap.size() || cap[i] !== exp[i]) begin nbad++; $display("FAIL stall_byte[%0d] got %h want %h", i, cap[i], exp[i]); end
    end
  endtask
  initial begin
    g1 = '0;
    g1[0] = 1'b1; g1[1] = 1'b1; g1[7] = 1'b1;
    g1[12] = 1'b1; g1[20] = 1'b1;
    g1[22] = 1'b1; g1[24] = 1'b1; g1[30] = 1'b1;
    g1[40] = 1'b1;
    for (int i = 0; i < GW; i++) ga[i] = ((i * 5) % 7) < 3;
    test_reset();
    test_small();
    test_full();
    test_bad_dims();
    test_ignore();
    test_reset_mid();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
